// File: rtl/awg_sweep_controller.sv
// Frequency sweep sequencer for the waveform generator: snapshots a sweep
// config on start and steps frequency from start to stop with a fixed dwell.
module awg_sweep_controller #(
    parameter int FREQ_W  = 17,
    parameter int AMP_W   = 10,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  cfg_start_freq,
    input  logic [FREQ_W-1:0]  cfg_stop_freq,
    input  logic [FREQ_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic [1:0]         cfg_waveform_type,
    input  logic [AMP_W-1:0]   cfg_amplitude,
    input  logic [AMP_W-1:0]   cfg_dc_offset,
    output logic [1:0]         waveform_type,
    output logic [FREQ_W-1:0]  frequency,
    output logic [AMP_W-1:0]   amplitude,
    output logic [AMP_W-1:0]   dc_offset,
    output logic               busy,
    output logic               step_strobe,
    output logic               sweep_done,
    output logic               cfg_err
);

    typedef enum logic {S_IDLE, S_DWELL} state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [FREQ_W-1:0]  s_start_q, s_start_d;
    logic [FREQ_W-1:0]  s_stop_q, s_stop_d;
    logic [FREQ_W-1:0]  s_step_q, s_step_d;
    logic [DWELL_W-1:0] s_dwell_q, s_dwell_d;
    logic               s_cont_q, s_cont_d;
    logic               s_up_q, s_up_d;

    logic [1:0]         wt_d;
    logic [FREQ_W-1:0]  freq_d, next_freq;
    logic [AMP_W-1:0]   amp_d, dco_d;
    logic               strobe_d, done_d, err_d;
    logic [FREQ_W:0]    sum, diff;

    // Step toward stop in FREQ_W+1 bits so overshoot clamps to stop instead of wrapping.
    always_comb begin
        sum  = {1'b0, frequency} + {1'b0, s_step_q};
        diff = {1'b0, frequency} - {1'b0, s_stop_q};
        if (s_up_q)
            next_freq = (sum > {1'b0, s_stop_q}) ? s_stop_q : sum[FREQ_W-1:0];
        else
            next_freq = (diff < {1'b0, s_step_q}) ? s_stop_q : frequency - s_step_q;
    end

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        s_start_d = s_start_q;
        s_stop_d  = s_stop_q;
        s_step_d  = s_step_q;
        s_dwell_d = s_dwell_q;
        s_cont_d  = s_cont_q;
        s_up_d    = s_up_q;
        wt_d      = waveform_type;
        freq_d    = frequency;
        amp_d     = amplitude;
        dco_d     = dc_offset;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            amp_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_step == '0 && cfg_start_freq != cfg_stop_freq) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = S_DWELL;
                            s_start_d = cfg_start_freq;
                            s_stop_d  = cfg_stop_freq;
                            s_step_d  = cfg_step;
                            s_cont_d  = cfg_continuous;
                            s_up_d    = (cfg_start_freq <= cfg_stop_freq);
                            // Dwell of 0 behaves as 1: hold each value for one cycle.
                            s_dwell_d = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
                            dwell_d   = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
                            wt_d      = cfg_waveform_type;
                            freq_d    = cfg_start_freq;
                            amp_d     = cfg_amplitude;
                            dco_d     = cfg_dc_offset;
                            strobe_d  = 1'b1;
                        end
                    end
                end
                S_DWELL: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end else if (frequency != s_stop_q) begin
                        freq_d   = next_freq;
                        strobe_d = 1'b1;
                        dwell_d  = s_dwell_q;
                    end else if (s_cont_q) begin
                        freq_d   = s_start_q;
                        strobe_d = 1'b1;
                        dwell_d  = s_dwell_q;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dwell_q       <= '0;
            s_start_q     <= '0;
            s_stop_q      <= '0;
            s_step_q      <= '0;
            s_dwell_q     <= '0;
            s_cont_q      <= 1'b0;
            s_up_q        <= 1'b0;
            waveform_type <= '0;
            frequency     <= '0;
            amplitude     <= '0;
            dc_offset     <= '0;
            step_strobe   <= 1'b0;
            sweep_done    <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            s_start_q     <= s_start_d;
            s_stop_q      <= s_stop_d;
            s_step_q      <= s_step_d;
            s_dwell_q     <= s_dwell_d;
            s_cont_q      <= s_cont_d;
            s_up_q        <= s_up_d;
            waveform_type <= wt_d;
            frequency     <= freq_d;
            amplitude     <= amp_d;
            dc_offset     <= dco_d;
            step_strobe   <= strobe_d;
            sweep_done    <= done_d;
            cfg_err       <= err_d;
        end
    end

    assign busy = (state_q == S_DWELL);

endmodule

// File: tb/tb_awg_sweep_controller.sv
// Directed bench for awg_sweep_controller with hand-computed expected values.
module tb_awg_sweep_controller;

    localparam int FREQ_W  = 17;
    localparam int AMP_W   = 10;
    localparam int DWELL_W = 24;

    logic               clk = 1'b0;
    logic               rst, start, abort;
    logic [FREQ_W-1:0]  cfg_start_freq, cfg_stop_freq, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_continuous;
    logic [1:0]         cfg_waveform_type;
    logic [AMP_W-1:0]   cfg_amplitude, cfg_dc_offset;
    logic [1:0]         waveform_type;
    logic [FREQ_W-1:0]  frequency;
    logic [AMP_W-1:0]   amplitude, dc_offset;
    logic               busy, step_strobe, sweep_done, cfg_err;

    int vectors = 0;
    int miscompares = 0;

    awg_sweep_controller #(.FREQ_W(FREQ_W), .AMP_W(AMP_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_continuous(cfg_continuous),
        .cfg_waveform_type(cfg_waveform_type), .cfg_amplitude(cfg_amplitude),
        .cfg_dc_offset(cfg_dc_offset), .waveform_type(waveform_type),
        .frequency(frequency), .amplitude(amplitude), .dc_offset(dc_offset),
        .busy(busy), .step_strobe(step_strobe), .sweep_done(sweep_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int sf, input int ef, input int st, input int dw,
                           input logic cont, input int wt, input int amp, input int dco);
        cfg_start_freq    = FREQ_W'(sf);
        cfg_stop_freq     = FREQ_W'(ef);
        cfg_step          = FREQ_W'(st);
        cfg_dwell         = DWELL_W'(dw);
        cfg_continuous    = cont;
        cfg_waveform_type = 2'(wt);
        cfg_amplitude     = AMP_W'(amp);
        cfg_dc_offset     = AMP_W'(dco);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int dn[4];
        int cq[9];
        int strobes;
        dn = '{500, 400, 300, 260};
        cq = '{10, 10, 20, 20, 30, 30, 10, 10, 20};
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_freq", frequency, 0);
        chk("rst_amp", amplitude, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {step_strobe, sweep_done, cfg_err}, 0);

        // Up sweep, single shot, dwell 4
        set_cfg(1000, 1300, 100, 4, 1'b0, 2, 512, 33);
        pulse_start();
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            chk("up_freq", frequency, 1000 + 100 * (i / 4));
            chk("up_busy", busy, 1);
            chk("up_strobe", step_strobe, (i % 4 == 0) ? 1 : 0);
            chk("up_nodone", sweep_done, 0);
            strobes += int'(step_strobe);
            if (i == 1) cfg_start_freq = 5;
            tick();
        end
        chk("up_strobe_cnt", strobes, 4);
        chk("up_done", sweep_done, 1);
        chk("up_busy_end", busy, 0);
        chk("up_freq_hold", frequency, 1300);
        chk("up_amp_hold", amplitude, 512);
        chk("up_wt", waveform_type, 2);
        chk("up_dco", dc_offset, 33);
        tick();
        chk("up_done_1cyc", sweep_done, 0);

        // Down sweep with clamp onto stop, dwell 1
        set_cfg(500, 260, 100, 1, 1'b0, 1, 200, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("dn_freq", frequency, dn[i]);
            chk("dn_strobe", step_strobe, 1);
            tick();
        end
        chk("dn_done", sweep_done, 1);
        chk("dn_busy", busy, 0);
        chk("dn_freq_hold", frequency, 260);

        // Continuous sweep, dwell 2
        set_cfg(10, 30, 10, 2, 1'b1, 1, 300, 7);
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            chk("ct_freq", frequency, cq[i]);
            chk("ct_strobe", step_strobe, (i % 2 == 0) ? 1 : 0);
            chk("ct_nodone", sweep_done, 0);
            tick();
        end
        // Start while busy (with a config that would be rejected) is ignored
        set_cfg(100, 200, 0, 3, 1'b0, 3, 99, 99);
        pulse_start();
        chk("busy_start_freq", frequency, 30);
        chk("busy_start_noerr", cfg_err, 0);
        chk("busy_start_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mute", amplitude, 0);
        chk("abort_freq", frequency, 30);
        chk("abort_wt", waveform_type, 1);
        chk("abort_dco", dc_offset, 7);
        chk("abort_nodone", sweep_done, 0);

        // Reject: step 0 with start != stop
        pulse_start();
        chk("rej_err", cfg_err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_freq", frequency, 30);
        chk("rej_amp", amplitude, 0);
        chk("rej_strobe", step_strobe, 0);
        tick();
        chk("rej_err_1cyc", cfg_err, 0);

        // start == stop, step 0, dwell 0 is accepted
        set_cfg(700, 700, 0, 0, 1'b0, 0, 100, 1);
        pulse_start();
        chk("eq_freq", frequency, 700);
        chk("eq_busy", busy, 1);
        chk("eq_strobe", step_strobe, 1);
        chk("eq_noerr", cfg_err, 0);
        tick();
        chk("eq_done", sweep_done, 1);
        chk("eq_busy_end", busy, 0);

        // Top-of-range clamp without overflow
        set_cfg(131000, 131071, 100, 1, 1'b0, 0, 100, 1);
        pulse_start();
        chk("top_f0", frequency, 131000);
        tick();
        chk("top_f1", frequency, 131071);
        chk("top_f1_strobe", step_strobe, 1);
        tick();
        chk("top_done", sweep_done, 1);
        chk("top_hold", frequency, 131071);

        // start and abort in the same cycle: abort wins
        set_cfg(50, 80, 10, 1, 1'b0, 2, 400, 2);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_strobe", step_strobe, 0);
        chk("sa_freq", frequency, 131071);

        // Reset mid-sweep
        pulse_start();
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_freq", frequency, 0);
        chk("mrst_amp", amplitude, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_pulses", {step_strobe, sweep_done, cfg_err}, 0);
        tick();
        chk("mrst_nodone", sweep_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
